// File: rtl/vsync_timing_gen.sv
// Four-phase vertical frame sequencer (active, front porch, sync, back porch), advanced by lineEnd.
// Define VSYNC_FRAME_COUNTER_EN to add the 16-bit frameCount output.
module vsync_timing_gen #(
  parameter int   busWidth     = 11,
  parameter int   resVertical  = 1080,
  parameter int   frontPorch   = 4,
  parameter int   syncWidth    = 5,
  parameter int   backPorch    = 36,
  parameter logic syncPolarity = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                lineEnd,
  output logic                vSyncPulse,
  output logic                vActive,
  output logic [busWidth-1:0] lineCount,
  output logic                frameStart,
  output logic                frameEnd
`ifdef VSYNC_FRAME_COUNTER_EN
  ,
  output logic [15:0]         frameCount
`endif
);

  localparam int totalLines = resVertical + frontPorch + syncWidth + backPorch;

  // Last phase index of each state; zero-length porches never use theirs.
  localparam logic [busWidth-1:0] activeLast = busWidth'(resVertical - 1);
  localparam logic [busWidth-1:0] frontLast  = busWidth'((frontPorch > 0) ? frontPorch - 1 : 0);
  localparam logic [busWidth-1:0] syncLast   = busWidth'(syncWidth - 1);
  localparam logic [busWidth-1:0] backLast   = busWidth'((backPorch > 0) ? backPorch - 1 : 0);
  localparam logic [busWidth-1:0] totalLast  = busWidth'(totalLines - 1);
  localparam logic [busWidth-1:0] one        = busWidth'(1);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } stateType;

  stateType            stateReg, stateNext;
  logic [busWidth-1:0] phaseReg, phaseNext;
  logic [busWidth-1:0] phaseLast;
  logic [busWidth-1:0] lineCountNext;
  logic                vActiveNext, vSyncNext, frameStartNext, frameEndNext;

  always_comb begin
    stateNext      = stateReg;
    phaseNext      = phaseReg;
    lineCountNext  = lineCount;
    frameStartNext = 1'b0;
    frameEndNext   = 1'b0;

    case (stateReg)
      ACTIVE:  phaseLast = activeLast;
      FRONT:   phaseLast = frontLast;
      SYNC:    phaseLast = syncLast;
      BACK:    phaseLast = backLast;
      default: phaseLast = activeLast;
    endcase

    if (lineEnd) begin
      lineCountNext  = (lineCount == totalLast) ? '0 : lineCount + one;
      frameStartNext = (lineCount == totalLast);
      frameEndNext   = (lineCount == activeLast);
      if (phaseReg == phaseLast) begin
        phaseNext = '0;
        case (stateReg)
          ACTIVE:  stateNext = (frontPorch == 0) ? SYNC : FRONT;
          FRONT:   stateNext = SYNC;
          SYNC:    stateNext = (backPorch == 0) ? ACTIVE : BACK;
          BACK:    stateNext = ACTIVE;
          default: stateNext = ACTIVE;
        endcase
      end else begin
        phaseNext = phaseReg + one;
      end
    end

    // Outputs come from the next state so they land on the same edge as the line change.
    vActiveNext = (stateNext == ACTIVE);
    vSyncNext   = (stateNext == SYNC) ? syncPolarity : ~syncPolarity;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg   <= ACTIVE;
      phaseReg   <= '0;
      lineCount  <= '0;
      vActive    <= 1'b1;
      vSyncPulse <= ~syncPolarity;
      frameStart <= 1'b0;
      frameEnd   <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      phaseReg   <= phaseNext;
      lineCount  <= lineCountNext;
      vActive    <= vActiveNext;
      vSyncPulse <= vSyncNext;
      frameStart <= frameStartNext;
      frameEnd   <= frameEndNext;
    end
  end

`ifdef VSYNC_FRAME_COUNTER_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      frameCount <= 16'd0;
    end else if (frameStartNext) begin
      frameCount <= frameCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vsync_timing_gen.sv
// Scoreboard bench for vsync_timing_gen: four instances with different geometries share one stimulus.
module tb_vsync_timing_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic lineEnd = 1'b0;

  logic [3:0]       va, vs, fs, fe;
  logic [3:0][10:0] lc;
  logic [3:0][15:0] fc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Geometry of each instance: res, front, sync, back, polarity.
  int cRes[4] = '{4, 4, 4, 1080};
  int cFp[4]  = '{1, 1, 0, 4};
  int cSw[4]  = '{2, 2, 2, 5};
  int cBp[4]  = '{1, 1, 0, 36};
  bit cPol[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  vsync_timing_gen #(.busWidth(11), .resVertical(4), .frontPorch(1), .syncWidth(2),
                     .backPorch(1), .syncPolarity(1'b1)) dut0 (
    .clock(clock), .reset(reset), .lineEnd(lineEnd), .vSyncPulse(vs[0]), .vActive(va[0]),
    .lineCount(lc[0]), .frameStart(fs[0]), .frameEnd(fe[0])
`ifdef VSYNC_FRAME_COUNTER_EN
    , .frameCount(fc[0])
`endif
  );

  vsync_timing_gen #(.busWidth(11), .resVertical(4), .frontPorch(1), .syncWidth(2),
                     .backPorch(1), .syncPolarity(1'b0)) dut1 (
    .clock(clock), .reset(reset), .lineEnd(lineEnd), .vSyncPulse(vs[1]), .vActive(va[1]),
    .lineCount(lc[1]), .frameStart(fs[1]), .frameEnd(fe[1])
`ifdef VSYNC_FRAME_COUNTER_EN
    , .frameCount(fc[1])
`endif
  );

  vsync_timing_gen #(.busWidth(11), .resVertical(4), .frontPorch(0), .syncWidth(2),
                     .backPorch(0), .syncPolarity(1'b1)) dut2 (
    .clock(clock), .reset(reset), .lineEnd(lineEnd), .vSyncPulse(vs[2]), .vActive(va[2]),
    .lineCount(lc[2]), .frameStart(fs[2]), .frameEnd(fe[2])
`ifdef VSYNC_FRAME_COUNTER_EN
    , .frameCount(fc[2])
`endif
  );

  vsync_timing_gen dut3 (
    .clock(clock), .reset(reset), .lineEnd(lineEnd), .vSyncPulse(vs[3]), .vActive(va[3]),
    .lineCount(lc[3]), .frameStart(fs[3]), .frameEnd(fe[3])
`ifdef VSYNC_FRAME_COUNTER_EN
    , .frameCount(fc[3])
`endif
  );

`ifndef VSYNC_FRAME_COUNTER_EN
  assign fc = '0;
`endif

  typedef struct {
    logic [10:0] lc;
    logic        va;
    logic        vs;
    logic        fs;
    logic        fe;
    logic [15:0] fc;
  } expType;

  expType sbq[$];

  int mLine[4];
  bit mFs[4];
  bit mFe[4];
  int mFc[4];

  // Reference model works from the line index alone, independent of any state machine.
  task automatic pushExpected(input bit le, input bit rst);
    expType e;
    int t, prev, sStart;
    for (int d = 0; d < 4; d++) begin
      t = cRes[d] + cFp[d] + cSw[d] + cBp[d];
      if (rst) begin
        mLine[d] = 0; mFs[d] = 1'b0; mFe[d] = 1'b0; mFc[d] = 0;
      end else if (le) begin
        prev     = mLine[d];
        mFs[d]   = (prev == t - 1);
        mFe[d]   = (prev == cRes[d] - 1);
        mLine[d] = (prev == t - 1) ? 0 : prev + 1;
        if (mFs[d]) mFc[d] = (mFc[d] + 1) % 65536;
      end else begin
        mFs[d] = 1'b0; mFe[d] = 1'b0;
      end
      sStart = cRes[d] + cFp[d];
      e.lc = 11'(mLine[d]);
      e.va = (mLine[d] < cRes[d]);
      e.vs = (mLine[d] >= sStart && mLine[d] < sStart + cSw[d]) ? cPol[d] : ~cPol[d];
      e.fs = mFs[d];
      e.fe = mFe[d];
      e.fc = 16'(mFc[d]);
      sbq.push_back(e);
    end
  endtask

  task automatic checkAll();
    expType e;
    for (int d = 0; d < 4; d++) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty dut%0d got none want entry", d);
      end else begin
        e = sbq.pop_front();
        checks++;
        assert (lc[d] === e.lc) else begin
          errors++; $error("FAIL lineCount dut%0d got %0d want %0d", d, lc[d], e.lc);
        end
        checks++;
        assert (va[d] === e.va) else begin
          errors++; $error("FAIL vActive dut%0d line %0d got %b want %b", d, e.lc, va[d], e.va);
        end
        checks++;
        assert (vs[d] === e.vs) else begin
          errors++; $error("FAIL vSyncPulse dut%0d line %0d got %b want %b", d, e.lc, vs[d], e.vs);
        end
        checks++;
        assert (fs[d] === e.fs) else begin
          errors++; $error("FAIL frameStart dut%0d line %0d got %b want %b", d, e.lc, fs[d], e.fs);
        end
        checks++;
        assert (fe[d] === e.fe) else begin
          errors++; $error("FAIL frameEnd dut%0d line %0d got %b want %b", d, e.lc, fe[d], e.fe);
        end
`ifdef VSYNC_FRAME_COUNTER_EN
        checks++;
        assert (fc[d] === e.fc) else begin
          errors++; $error("FAIL frameCount dut%0d got %0d want %0d", d, fc[d], e.fc);
        end
`endif
      end
    end
  endtask

  // One clock: drive at the falling edge, predict, then sample 1 time unit after the rising edge.
  task automatic step(input bit le, input bit rst);
    @(negedge clock);
    lineEnd = le;
    reset   = rst;
    pushExpected(le, rst);
    @(posedge clock);
    #1;
    checkAll();
  endtask

  initial begin
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Eight strobes spaced ten clocks apart: one full frame for the T=8 instances.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      for (int k = 0; k < 9; k++) step(1'b0, 1'b0);
    end

    // Sixteen back-to-back strobes from reset: two complete frames.
    step(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Walk to line 5 (sync) then hit reset together with lineEnd.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);

    // 1125 strobes return the 1080p instance to line 0.
    for (int i = 0; i < 1125; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    checks++;
    assert (lc[3] === 11'd0) else begin
      errors++; $error("FAIL wrap1080 got %0d want 0", lc[3]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
